// File: rtl/alu_host_pkg.sv
// Shared opcodes (identical to the ALU command encoding), FSM states and error bit positions
// for the alu_host sequencer.
package alu_host_pkg;

    localparam logic [3:0] OP_LOAD   = 4'd0;
    localparam logic [3:0] OP_ADD    = 4'd1;
    localparam logic [3:0] OP_SUB    = 4'd2;
    localparam logic [3:0] OP_MUL    = 4'd3;
    localparam logic [3:0] OP_DIV    = 4'd4;
    localparam logic [3:0] OP_MOD    = 4'd5;
    localparam logic [3:0] OP_CLRERR = 4'd6;

    localparam int ERR_DBZ = 1;
    localparam int ERR_OVF = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RESPOND = 2'd2
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MOD);
    endfunction

endpackage

// File: rtl/alu_host_settle_cnt.sv
// Loadable down-counter with a zero flag; times how long the ALU lanes are held before capture.
module alu_host_settle_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/alu_host.sv
// Accumulator sequencer in front of the 16-bit combinational ALU.
// Optional build macro ALU_HOST_DBZ_GUARD_EN: DIV/MOD by zero answered locally, never issued.
module alu_host #(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [15:0] in_operand,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [3:0]  alu_cmd,
    input  logic [31:0] alu_result,
    input  logic [1:0]  alu_error,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [1:0]  out_error,
    output logic [15:0] acc,
    output logic [1:0]  sticky_err
);
    import alu_host_pkg::*;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_op;
    logic [15:0] r_operand;
    logic [15:0] r_acc;
    logic [31:0] r_out_result;
    logic [1:0]  r_out_error;
    logic [1:0]  r_sticky;

    logic        w_in_hs;
    logic        w_guard_hit;
    logic        w_direct;
    logic        w_cnt_load;
    logic        w_cnt_dec;
    logic        w_cnt_zero;
    logic        w_capture;
    logic [1:0]  w_cap_err;

`ifdef ALU_HOST_DBZ_GUARD_EN
    assign w_guard_hit = ((in_op == OP_DIV) || (in_op == OP_MOD)) && (in_operand == 16'h0);
`else
    assign w_guard_hit = 1'b0;
`endif

    // Ops answered without touching the ALU respond one cycle after acceptance.
    assign w_direct = !is_alu_op(in_op) || w_guard_hit;
    assign w_in_hs  = in_valid && (r_state == ST_IDLE);

    alu_host_settle_cnt #(
        .W (4)
    ) u_settle_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (SETTLE_LOAD),
        .i_dec      (w_cnt_dec),
        .o_zero     (w_cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_load   = 1'b0;
        w_cnt_dec    = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (w_direct) begin
                        w_state_next = ST_RESPOND;
                    end else begin
                        w_state_next = ST_ISSUE;
                        w_cnt_load   = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                w_cnt_dec = 1'b1;
                if (w_cnt_zero) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // The ALU raises overflow spuriously for non-add/sub commands, so each flag is qualified.
    always_comb begin
        w_cap_err          = 2'b00;
        w_cap_err[ERR_OVF] = alu_error[ERR_OVF] && ((r_op == OP_ADD) || (r_op == OP_SUB));
        w_cap_err[ERR_DBZ] = alu_error[ERR_DBZ] && ((r_op == OP_DIV) || (r_op == OP_MOD));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op         <= OP_LOAD;
            r_operand    <= 16'h0;
            r_acc        <= 16'h0;
            r_out_result <= 32'h0;
            r_out_error  <= 2'b00;
            r_sticky     <= 2'b00;
        end else begin
            if (w_in_hs) begin
                r_op      <= in_op;
                r_operand <= in_operand;
                if (w_direct) begin
                    case (in_op)
                        OP_LOAD: begin
                            r_acc        <= in_operand;
                            r_out_result <= {16'h0, in_operand};
                            r_out_error  <= 2'b00;
                        end
                        OP_CLRERR: begin
                            r_sticky     <= 2'b00;
                            r_out_result <= {16'h0, r_acc};
                            r_out_error  <= 2'b00;
                        end
                        OP_DIV, OP_MOD: begin
                            r_out_result <= 32'h0;
                            r_out_error  <= 2'b10;
                            r_sticky     <= r_sticky | 2'b10;
                        end
                        default: begin
                            r_out_result <= 32'h0;
                            r_out_error  <= 2'b11;
                            r_sticky     <= r_sticky | 2'b11;
                        end
                    endcase
                end
            end
            if (w_capture) begin
                r_out_result <= alu_result;
                r_out_error  <= w_cap_err;
                r_sticky     <= r_sticky | w_cap_err;
                if (!w_cap_err[ERR_DBZ]) begin
                    r_acc <= alu_result[15:0];
                end
            end
        end
    end

    assign in_ready   = (r_state == ST_IDLE);
    assign out_valid  = (r_state == ST_RESPOND);
    assign alu_a      = (r_state == ST_ISSUE) ? r_acc     : 16'h0;
    assign alu_b      = (r_state == ST_ISSUE) ? r_operand : 16'h0;
    assign alu_cmd    = (r_state == ST_ISSUE) ? r_op      : 4'h0;
    assign out_result = r_out_result;
    assign out_error  = r_out_error;
    assign acc        = r_acc;
    assign sticky_err = r_sticky;

endmodule

// File: tb/tb_alu_host.sv
// Bench for alu_host: a stub ALU on the command lanes plus an arithmetic reference model.
module tb_alu_host;

    localparam int S = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  in_op = 4'd0;
    logic [15:0] in_operand = 16'd0;
    logic        in_ready, out_valid;
    logic [3:0]  alu_cmd;
    logic [15:0] alu_a, alu_b, acc;
    logic [31:0] alu_result, out_result;
    logic [1:0]  alu_error, out_error, sticky_err;

    int total = 0;
    int bad = 0;

    logic [15:0] m_acc = 16'd0;
    logic [1:0]  m_sticky = 2'b00;

    int          issue_cycles = 0;
    logic [15:0] seen_a = 16'd0;
    logic [15:0] seen_b = 16'd0;
    logic [3:0]  seen_cmd = 4'd0;

    alu_host #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_operand (in_operand),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_cmd    (alu_cmd),
        .alu_result (alu_result),
        .alu_error  (alu_error),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_error  (out_error),
        .acc        (acc),
        .sticky_err (sticky_err)
    );

    always #5 clk = ~clk;

    // Stub ALU: flags overflow spuriously on MUL/DIV/MOD, returns all-ones on divide by zero.
    int stub_s;
    always_comb begin
        alu_result = 32'h0;
        alu_error  = 2'b00;
        stub_s     = 0;
        case (alu_cmd)
            4'd1: begin
                stub_s       = $signed(alu_a) + $signed(alu_b);
                alu_result   = {16'h0, 16'(stub_s)};
                alu_error[0] = (stub_s > 32767) || (stub_s < -32768);
            end
            4'd2: begin
                stub_s       = $signed(alu_a) - $signed(alu_b);
                alu_result   = {16'h0, 16'(stub_s)};
                alu_error[0] = (stub_s > 32767) || (stub_s < -32768);
            end
            4'd3: begin
                alu_result = 32'(alu_a) * 32'(alu_b);
                alu_error  = 2'b01;
            end
            4'd4, 4'd5: begin
                if (alu_b == 16'h0) begin
                    alu_result = 32'hFFFF_FFFF;
                    alu_error  = 2'b11;
                end else begin
                    alu_result = (alu_cmd == 4'd4) ? {16'h0, alu_a / alu_b} : {16'h0, alu_a % alu_b};
                    alu_error  = 2'b01;
                end
            end
            default: ;
        endcase
    end

    always @(negedge clk) begin
        if (alu_cmd != 4'd0) begin
            issue_cycles <= issue_cycles + 1;
            seen_a       <= alu_a;
            seen_b       <= alu_b;
            seen_cmd     <= alu_cmd;
        end
    end

    // Reference model: expected response, latency and ALU issue length of one instruction.
    task automatic model_op(input logic [3:0] op, input logic [15:0] operand,
                            output logic [31:0] r, output logic [1:0] e,
                            output int lat, output int iss);
        int sa, sb, sum;
        r = 32'h0; e = 2'b00; lat = 1; iss = 0;
        sa = $signed(m_acc);
        sb = $signed(operand);
        case (op)
            4'd0: begin
                m_acc = operand;
                r = {16'h0, operand};
            end
            4'd1, 4'd2: begin
                sum = (op == 4'd1) ? sa + sb : sa - sb;
                e[0] = (sum > 32767) || (sum < -32768);
                r = {16'h0, 16'(sum)};
                m_acc = 16'(sum);
                lat = S + 1; iss = S;
            end
            4'd3: begin
                r = 32'(m_acc) * 32'(operand);
                m_acc = r[15:0];
                lat = S + 1; iss = S;
            end
            4'd4, 4'd5: begin
                if (operand == 16'h0) begin
                    e = 2'b10;
`ifdef ALU_HOST_DBZ_GUARD_EN
                    r = 32'h0;
`else
                    r = 32'hFFFF_FFFF;
                    lat = S + 1; iss = S;
`endif
                end else begin
                    r = (op == 4'd4) ? 32'(m_acc / operand) : 32'(m_acc % operand);
                    m_acc = r[15:0];
                    lat = S + 1; iss = S;
                end
            end
            4'd6: begin
                r = {16'h0, m_acc};
                m_sticky = 2'b00;
            end
            default: e = 2'b11;
        endcase
        if (op != 4'd6) m_sticky = m_sticky | e;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [15:0] operand, input int hold,
                         output logic [31:0] res, output logic [1:0] err,
                         output int lat, output int iss);
        int n, base;
        @(negedge clk);
        in_op = op; in_operand = operand; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        total++;
        if (!in_ready) begin bad++; $display("FAIL accept_timeout op=%0d: in_ready got 0 want 1", op); end
        base = issue_cycles;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 50) begin @(negedge clk); lat++; end
        total++;
        if (!out_valid) begin bad++; $display("FAIL response_timeout op=%0d: out_valid got 0 want 1", op); end
        res = out_result; err = out_error;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        iss = issue_cycles - base;
        $display("op=%0d operand=%0d result=%0d error=%b acc=%0d sticky=%b lat=%0d",
                 op, operand, res, err, acc, sticky_err, lat);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (acc !== 16'h0) begin bad++; $display("FAIL reset_acc: got %0d want 0", acc); end
        total++; if (sticky_err !== 2'b00) begin bad++; $display("FAIL reset_sticky: got %b want 00", sticky_err); end
        total++; if ({out_result, out_error} !== 34'h0) begin bad++; $display("FAIL reset_out: got %0d/%b want 0/00", out_result, out_error); end
        total++; if ({alu_a, alu_b, alu_cmd} !== 36'h0) begin bad++; $display("FAIL reset_lanes: got %h/%h/%h want 0", alu_a, alu_b, alu_cmd); end
        rst_n = 1'b1;
        m_acc = 16'h0; m_sticky = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_load_add;
        logic [31:0] r, er; logic [1:0] e, ee; int l, el, i, ei;
        model_op(4'd0, 16'd249, er, ee, el, ei);
        do_op(4'd0, 16'd249, 0, r, e, l, i);
        total++; if (r !== er || l !== el) begin bad++; $display("FAIL load: got %0d lat %0d want %0d lat %0d", r, l, er, el); end
        model_op(4'd1, 16'd69, er, ee, el, ei);
        do_op(4'd1, 16'd69, 0, r, e, l, i);
        total++; if (r !== er || e !== ee) begin bad++; $display("FAIL add: got %0d/%b want %0d/%b", r, e, er, ee); end
        total++; if (acc !== m_acc) begin bad++; $display("FAIL add_acc: got %0d want %0d", acc, m_acc); end
        total++; if (l !== el || i !== ei) begin bad++; $display("FAIL add_timing: got lat %0d iss %0d want %0d %0d", l, i, el, ei); end
        total++; if (seen_a !== 16'd249 || seen_b !== 16'd69 || seen_cmd !== 4'd1) begin
            bad++; $display("FAIL add_lanes: got %0d/%0d/%0d want 249/69/1", seen_a, seen_b, seen_cmd); end
    endtask

    task automatic test_overflow_clrerr;
        logic [31:0] r, er; logic [1:0] e, ee; int l, el, i, ei;
        model_op(4'd0, 16'd32000, er, ee, el, ei);
        do_op(4'd0, 16'd32000, 0, r, e, l, i);
        model_op(4'd1, 16'd16001, er, ee, el, ei);
        do_op(4'd1, 16'd16001, 1, r, e, l, i);
        total++; if (e !== ee || acc !== m_acc) begin bad++; $display("FAIL ovf_add: got err %b acc %h want %b %h", e, acc, ee, m_acc); end
        total++; if (sticky_err !== m_sticky) begin bad++; $display("FAIL ovf_sticky: got %b want %b", sticky_err, m_sticky); end
        model_op(4'd6, 16'd0, er, ee, el, ei);
        do_op(4'd6, 16'd0, 0, r, e, l, i);
        total++; if (sticky_err !== m_sticky || r !== er) begin
            bad++; $display("FAIL clrerr: got sticky %b result %0d want %b %0d", sticky_err, r, m_sticky, er); end
        total++; if (l !== el || i !== ei) begin bad++; $display("FAIL clrerr_timing: got lat %0d iss %0d want %0d %0d", l, i, el, ei); end
    endtask

    task automatic test_muldivmod;
        logic [31:0] r, er; logic [1:0] e, ee; int l, el, i, ei;
        logic [3:0] ops [4];
        ops = '{4'd0, 4'd3, 4'd4, 4'd5};
        foreach (ops[k]) begin
            model_op(ops[k], (k == 0) ? 16'd249 : 16'd69, er, ee, el, ei);
            if (k == 1) begin
                model_op(4'd0, 16'd249, er, ee, el, ei);
                model_op(4'd3, 16'd69, er, ee, el, ei);
            end
            do_op(ops[k], (k == 0) ? 16'd249 : 16'd69, 0, r, e, l, i);
            if (k == 1) do_op(4'd0, 16'd249, 0, r, e, l, i);
            if (k == 1) do_op(4'd3, 16'd69, 0, r, e, l, i);
            total++; if (r !== er || e !== ee || acc !== m_acc) begin
                bad++; $display("FAIL muldivmod op=%0d: got %0d/%b acc %0d want %0d/%b acc %0d", ops[k], r, e, acc, er, ee, m_acc); end
        end
    endtask

    task automatic test_div_zero;
        logic [31:0] r, er; logic [1:0] e, ee; int l, el, i, ei;
        model_op(4'd0, 16'd249, er, ee, el, ei);
        do_op(4'd0, 16'd249, 0, r, e, l, i);
        model_op(4'd4, 16'd0, er, ee, el, ei);
        do_op(4'd4, 16'd0, 0, r, e, l, i);
        total++; if (r !== er || e !== ee) begin bad++; $display("FAIL dbz: got %h/%b want %h/%b", r, e, er, ee); end
        total++; if (acc !== m_acc || sticky_err !== m_sticky) begin
            bad++; $display("FAIL dbz_state: got acc %0d sticky %b want %0d %b", acc, sticky_err, m_acc, m_sticky); end
        total++; if (i !== ei || l !== el) begin bad++; $display("FAIL dbz_issue: got iss %0d lat %0d want %0d %0d", i, l, ei, el); end
    endtask

    task automatic test_illegal;
        logic [31:0] r, er; logic [1:0] e, ee; int l, el, i, ei;
        model_op(4'd9, 16'd1234, er, ee, el, ei);
        do_op(4'd9, 16'd1234, 0, r, e, l, i);
        total++; if (r !== er || e !== ee || acc !== m_acc) begin
            bad++; $display("FAIL illegal: got %0d/%b acc %0d want %0d/%b acc %0d", r, e, acc, er, ee, m_acc); end
        total++; if (i !== ei || l !== el) begin bad++; $display("FAIL illegal_timing: got iss %0d lat %0d want %0d %0d", i, l, ei, el); end
    endtask

    task automatic test_backpressure;
        logic [31:0] r0, er; logic [1:0] e0, ee; int el, ei, n;
        model_op(4'd1, 16'd1000, er, ee, el, ei);
        @(negedge clk);
        in_op = 4'd1; in_operand = 16'd1000; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        in_op = 4'd2; in_operand = 16'd7;
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        r0 = out_result; e0 = out_error;
        total++; if (r0 !== er || e0 !== ee) begin bad++; $display("FAIL bp_result: got %0d/%b want %0d/%b", r0, e0, er, ee); end
        repeat (5) begin
            total++;
            if (out_result !== r0 || out_error !== e0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                bad++; $display("FAIL bp_hold: got %0d/%b rdy %b vld %b want %0d/%b 0 1", out_result, out_error, in_ready, out_valid, r0, e0);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_release: got rdy %b vld %b want 1 0", in_ready, out_valid); end
        model_op(4'd2, 16'd7, er, ee, el, ei);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        total++; if (out_result !== er || acc !== m_acc || n !== el) begin
            bad++; $display("FAIL bp_second: got %0d acc %0d lat %0d want %0d %0d %0d", out_result, acc, n, er, m_acc, el); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] r, er; logic [1:0] e, ee; int l, el, i, ei, n; logic seen;
        model_op(4'd0, 16'd5, er, ee, el, ei);
        do_op(4'd0, 16'd5, 0, r, e, l, i);
        @(negedge clk);
        in_op = 4'd3; in_operand = 16'd100; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (alu_cmd !== 4'd3) begin bad++; $display("FAIL mid_issuing: got cmd %0d want 3", alu_cmd); end
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || acc !== 16'h0 || alu_cmd !== 4'd0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL mid_reset: got vld %b acc %0d cmd %0d rdy %b want 0 0 0 1", out_valid, acc, alu_cmd, in_ready); end
        rst_n = 1'b1;
        m_acc = 16'h0; m_sticky = 2'b00;
        seen = 1'b0;
        repeat (20) begin @(negedge clk); if (out_valid) seen = 1'b1; end
        total++; if (seen !== 1'b0 || sticky_err !== 2'b00) begin
            bad++; $display("FAIL mid_no_response: got vld_seen %b sticky %b want 0 00", seen, sticky_err); end
    endtask

    task automatic test_random;
        logic [31:0] r, er; logic [1:0] e, ee; int l, el, i, ei;
        logic [3:0] op; logic [15:0] operand;
        for (int k = 0; k < 60; k++) begin
            op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(7, 15));
            case ($urandom_range(0, 3))
                0:       operand = 16'h0;
                1:       operand = 16'($urandom_range(1, 20));
                default: operand = 16'($urandom);
            endcase
            model_op(op, operand, er, ee, el, ei);
            do_op(op, operand, int'($urandom_range(0, 2)), r, e, l, i);
            total++; if (r !== er || e !== ee) begin
                bad++; $display("FAIL rand_resp op=%0d opnd=%0d: got %h/%b want %h/%b", op, operand, r, e, er, ee); end
            total++; if (acc !== m_acc || sticky_err !== m_sticky) begin
                bad++; $display("FAIL rand_state op=%0d: got acc %h sticky %b want %h %b", op, acc, sticky_err, m_acc, m_sticky); end
            total++; if (l !== el || i !== ei) begin
                bad++; $display("FAIL rand_timing op=%0d: got lat %0d iss %0d want %0d %0d", op, l, i, el, ei); end
        end
    endtask

    initial begin
        test_reset;
        test_load_add;
        test_overflow_clrerr;
        test_muldivmod;
        test_div_zero;
        test_illegal;
        test_backpressure;
        test_reset_mid_op;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
